// File: rtl/rename_register_file.sv
// Architectural register file with per-register rename tags for the Tomasulo core.
// Source reads are combinational and bypass a matching same-cycle commit.
module rename_register_file #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_COUNT = 32,
    parameter int unsigned TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rollback_in,
    input  logic                 dec_issue_in,
    input  logic [4:0]           dec_rd_in,
    input  logic [TAG_WIDTH-1:0] dec_tag_in,
    input  logic [4:0]           dec_rs1_in,
    input  logic [4:0]           dec_rs2_in,
    output logic [XLEN-1:0]      dec_Vj_out,
    output logic [TAG_WIDTH-1:0] dec_Qj_out,
    output logic [XLEN-1:0]      dec_Vk_out,
    output logic [TAG_WIDTH-1:0] dec_Qk_out,
    input  logic                 commit_rf_signal_in,
    input  logic [4:0]           commit_target_in,
    input  logic [TAG_WIDTH-1:0] commit_tag_in,
    input  logic [XLEN-1:0]      commit_data_in
);

    logic [XLEN-1:0]      value_q [REG_COUNT];
    logic [XLEN-1:0]      value_d [REG_COUNT];
    logic [TAG_WIDTH-1:0] tag_q   [REG_COUNT];
    logic [TAG_WIDTH-1:0] tag_d   [REG_COUNT];

    logic commit_en;
    logic issue_en;

    assign commit_en = commit_rf_signal_in && (commit_target_in != 5'd0);
    assign issue_en  = dec_issue_in && (dec_rd_in != 5'd0) && !rollback_in;

    // Issue is applied after the commit so it overrides the commit's tag clear.
    always_comb begin
        for (int i = 0; i < int'(REG_COUNT); i++) begin
            value_d[i] = value_q[i];
            tag_d[i]   = tag_q[i];
        end
        if (commit_en) begin
            value_d[commit_target_in] = commit_data_in;
            if (tag_q[commit_target_in] == commit_tag_in) begin
                tag_d[commit_target_in] = '0;
            end
        end
        if (rollback_in) begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                tag_d[i] = '0;
            end
        end else if (issue_en) begin
            tag_d[dec_rd_in] = dec_tag_in;
        end
        value_d[0] = '0;
        tag_d[0]   = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                value_q[i] <= value_d[i];
                tag_q[i]   <= tag_d[i];
            end
        end
    end

    logic [TAG_WIDTH-1:0] rs1_tag;
    logic [TAG_WIDTH-1:0] rs2_tag;
    logic                 rs1_bypass;
    logic                 rs2_bypass;

    assign rs1_tag = tag_q[dec_rs1_in];
    assign rs2_tag = tag_q[dec_rs2_in];

    // Nonzero tags only live on x1..x31, so x0 never bypasses.
    assign rs1_bypass = (rs1_tag != '0) && commit_rf_signal_in &&
                        (commit_target_in == dec_rs1_in) && (commit_tag_in == rs1_tag);
    assign rs2_bypass = (rs2_tag != '0) && commit_rf_signal_in &&
                        (commit_target_in == dec_rs2_in) && (commit_tag_in == rs2_tag);

    always_comb begin
        dec_Vj_out = value_q[dec_rs1_in];
        dec_Qj_out = rs1_tag;
        if (rs1_bypass) begin
            dec_Vj_out = commit_data_in;
            dec_Qj_out = '0;
        end
    end

    always_comb begin
        dec_Vk_out = value_q[dec_rs2_in];
        dec_Qk_out = rs2_tag;
        if (rs2_bypass) begin
            dec_Vk_out = commit_data_in;
            dec_Qk_out = '0;
        end
    end

endmodule

// File: tb/tb_rename_register_file.sv
// Directed bench for rename_register_file; expected read results are queued by the
// stimulus and compared by a separate monitor on the falling clock edge.
module tb_rename_register_file;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned TAG_WIDTH = 4;
    localparam int unsigned EW        = 2 * (XLEN + TAG_WIDTH);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 rollback_in;
    logic                 dec_issue_in;
    logic [4:0]           dec_rd_in;
    logic [TAG_WIDTH-1:0] dec_tag_in;
    logic [4:0]           dec_rs1_in;
    logic [4:0]           dec_rs2_in;
    logic [XLEN-1:0]      dec_Vj_out;
    logic [TAG_WIDTH-1:0] dec_Qj_out;
    logic [XLEN-1:0]      dec_Vk_out;
    logic [TAG_WIDTH-1:0] dec_Qk_out;
    logic                 commit_rf_signal_in;
    logic [4:0]           commit_target_in;
    logic [TAG_WIDTH-1:0] commit_tag_in;
    logic [XLEN-1:0]      commit_data_in;

    rename_register_file #(
        .XLEN     (XLEN),
        .REG_COUNT(32),
        .TAG_WIDTH(TAG_WIDTH)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .rollback_in        (rollback_in),
        .dec_issue_in       (dec_issue_in),
        .dec_rd_in          (dec_rd_in),
        .dec_tag_in         (dec_tag_in),
        .dec_rs1_in         (dec_rs1_in),
        .dec_rs2_in         (dec_rs2_in),
        .dec_Vj_out         (dec_Vj_out),
        .dec_Qj_out         (dec_Qj_out),
        .dec_Vk_out         (dec_Vk_out),
        .dec_Qk_out         (dec_Qk_out),
        .commit_rf_signal_in(commit_rf_signal_in),
        .commit_target_in   (commit_target_in),
        .commit_tag_in      (commit_tag_in),
        .commit_data_in     (commit_data_in)
    );

    always #5 clk = ~clk;

    logic [EW-1:0] exp_q [$];
    string         name_q [$];
    logic          chk_valid = 1'b0;
    int            checks = 0;
    int            errors = 0;

    // Monitor: compares the DUT read ports against the oldest queued expectation.
    always @(negedge clk) begin
        if (chk_valid) begin
            logic [EW-1:0] exp;
            logic [EW-1:0] act;
            string         nm;
            act = {dec_Vj_out, dec_Qj_out, dec_Vk_out, dec_Qk_out};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL no_expectation: got Vj=%h Qj=%0d Vk=%h Qk=%0d, expected nothing",
                         dec_Vj_out, dec_Qj_out, dec_Vk_out, dec_Qk_out);
            end else begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL %s: got Vj=%h Qj=%0d Vk=%h Qk=%0d, expected Vj=%h Qj=%0d Vk=%h Qk=%0d",
                             nm, dec_Vj_out, dec_Qj_out, dec_Vk_out, dec_Qk_out,
                             exp[EW-1 -: XLEN], exp[XLEN+2*TAG_WIDTH-1 -: TAG_WIDTH],
                             exp[XLEN+TAG_WIDTH-1 -: XLEN], exp[TAG_WIDTH-1:0]);
                end
            end
        end
    end

    task automatic expect_rd(input string nm, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [XLEN-1:0] vj, input logic [TAG_WIDTH-1:0] qj,
                             input logic [XLEN-1:0] vk, input logic [TAG_WIDTH-1:0] qk);
        dec_rs1_in = rs1;
        dec_rs2_in = rs2;
        exp_q.push_back({vj, qj, vk, qk});
        name_q.push_back(nm);
        chk_valid = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk_valid           = 1'b0;
        rollback_in         = 1'b0;
        dec_issue_in        = 1'b0;
        dec_rd_in           = '0;
        dec_tag_in          = '0;
        dec_rs1_in          = '0;
        dec_rs2_in          = '0;
        commit_rf_signal_in = 1'b0;
        commit_target_in    = '0;
        commit_tag_in       = '0;
        commit_data_in      = '0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [TAG_WIDTH-1:0] tg);
        dec_issue_in = 1'b1;
        dec_rd_in    = rd;
        dec_tag_in   = tg;
    endtask

    task automatic commit(input logic [4:0] tgt, input logic [TAG_WIDTH-1:0] tg,
                          input logic [XLEN-1:0] data);
        commit_rf_signal_in = 1'b1;
        commit_target_in    = tgt;
        commit_tag_in       = tg;
        commit_data_in      = data;
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        expect_rd("reset_x5_x0", 5, 0, 0, 0, 0, 0);
        tick();
        issue(3, 5);
        expect_rd("issue_not_visible_same_cycle", 3, 3, 0, 0, 0, 0);
        tick();
        expect_rd("x3_pending_tag5", 3, 0, 0, 5, 0, 0);
        tick();
        commit(3, 5, 32'hDEAD_BEEF);
        expect_rd("commit_bypass_x3", 3, 3, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0);
        tick();
        expect_rd("x3_committed", 3, 5, 32'hDEAD_BEEF, 0, 0, 0);
        tick();

        issue(4, 2);
        expect_rd("x4_before_issue", 4, 0, 0, 0, 0, 0);
        tick();
        issue(4, 6);
        expect_rd("x4_tag2", 4, 0, 0, 2, 0, 0);
        tick();
        commit(4, 2, 32'h11);
        expect_rd("stale_commit_no_bypass", 4, 3, 0, 6, 32'hDEAD_BEEF, 0);
        tick();
        expect_rd("x4_value_kept_tag6", 4, 0, 32'h11, 6, 0, 0);
        tick();

        issue(7, 3);
        tick();
        commit(7, 3, 32'h42);
        issue(7, 9);
        expect_rd("commit_issue_same_cycle_read", 7, 7, 32'h42, 0, 32'h42, 0);
        tick();
        expect_rd("issue_wins_tag_clear", 7, 4, 32'h42, 9, 32'h11, 6);
        tick();

        issue(1, 10);
        tick();
        issue(2, 11);
        tick();
        issue(8, 12);
        expect_rd("x1_x2_pending", 1, 2, 0, 10, 0, 11);
        tick();
        rollback_in = 1'b1;
        issue(9, 4);
        commit(1, 13, 32'h77);
        expect_rd("pre_rollback_reads", 8, 1, 0, 12, 0, 10);
        tick();
        expect_rd("rollback_commit_kept", 1, 9, 32'h77, 0, 0, 0);
        tick();
        expect_rd("rollback_tags_cleared", 8, 7, 0, 0, 32'h42, 0);
        tick();
        expect_rd("rollback_values_kept", 4, 3, 32'h11, 0, 32'hDEAD_BEEF, 0);
        tick();

        issue(0, 3);
        commit(0, 0, 32'h5);
        expect_rd("x0_same_cycle", 0, 0, 0, 0, 0, 0);
        tick();
        expect_rd("x0_after_write", 0, 2, 0, 0, 0, 0);
        tick();

        issue(3, 7);
        tick();
        expect_rd("x3_tag7_before_reset", 3, 4, 32'hDEAD_BEEF, 7, 32'h11, 0);
        tick();
        rst = 1'b1;
        expect_rd("async_reset_immediate", 3, 4, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        expect_rd("after_reset", 3, 7, 0, 0, 0, 0);
        tick();
        tick();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
